i2c_reg_target: RTL and testbench

- Fully synchronous I2C target (responder) for the i2c_master initiator; oversamples SCL/SDA in the system clock domain. No logic is clocked by SCL.
- Holds a small byte-wide register bank. The I2C side reads and writes the bank through an auto-incrementing pointer. Local logic has its own read/write port.
- Sits between the board I2C pins and on-chip control/status logic.

---
 rtl/i2c_reg_target_pkg.sv | 27 ++
 rtl/i2c_reg_target_if.sv | 27 ++
 rtl/i2c_reg_target_line_sync.sv | 63 ++++++
 rtl/i2c_reg_target.sv | 188 ++++++++++++++++++
 tb/tb_i2c_reg_target.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_reg_target_pkg.sv
// Shared definitions for the I2C register target: FSM encoding and byte framing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_reg_target_pkg;

  // Data bits per I2C byte, excluding the ACK slot.
  localparam logic [3:0] BYTE_BITS = 4'd8;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WRITE     = 4'd5,
    ST_WRITE_ACK = 4'd6,
    ST_READ      = 4'd7,
    ST_READ_ACK  = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_t;

  // True when the address byte selects this target (bit 0 is R/W).
  function automatic logic addr_match(input logic [7:0] b, input logic [6:0] a);
    return b[7:1] == a;
  endfunction

endpackage

// File: rtl/i2c_reg_target_if.sv
// Local-side port of the register target: register access plus bus status.
// Latency: loc_rdata is combinational; loc_we takes effect on the next clock.
// Backpressure: none; every local write is accepted.
interface i2c_reg_target_if #(
  parameter int PTR_W = 3
);
  logic                                             loc_we;
  logic [PTR_W-1:0]                                 loc_idx;
  logic [i2c_reg_target_pkg::BYTE_BITS-1:0]         loc_wdata;
  logic [i2c_reg_target_pkg::BYTE_BITS-1:0]         loc_rdata;
  logic                                             busy;
  logic                                             addressed;
  logic                                             wr_strobe;
  logic [PTR_W-1:0]                                 wr_idx;

  // On-chip logic that owns the local port.
  modport master (
    output loc_we, loc_idx, loc_wdata,
    input  loc_rdata, busy, addressed, wr_strobe, wr_idx
  );

  // The register target itself.
  modport slave (
    input  loc_we, loc_idx, loc_wdata,
    output loc_rdata, busy, addressed, wr_strobe, wr_idx
  );
endinterface

// File: rtl/i2c_reg_target_line_sync.sv
// Synchronizes SCL/SDA into the system clock and flags START/STOP/SCL edges.
// Latency: SYNC_STAGES+1 clocks from pin change to condition pulse.
// Backpressure: none; pulses are single-cycle and must be consumed at once.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_start,
  output logic o_stop,
  output logic o_scl_rise,
  output logic o_scl_fall
);
  localparam int SETTLE = SYNC_STAGES + 1;
  localparam int SW     = $clog2(SETTLE + 1);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic [SW-1:0]          r_settle;
  logic                   w_scl;
  logic                   w_sda;
  logic                   w_ok;

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  // Shift the pins through the synchronizer; reset to the idle-high bus level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  // Mask conditions until the chain holds real pin values, so the forced
  // idle-high reset level cannot fake a START against a low SDA.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_settle <= '0;
    end else if (!w_ok) begin
      r_settle <= r_settle + SW'(1);
    end
  end

  assign w_ok       = (r_settle == SW'(SETTLE));
  assign o_sda      = w_sda;
  assign o_start    = w_ok &  w_scl &  r_sda_d & ~w_sda;
  assign o_stop     = w_ok &  w_scl & ~r_sda_d &  w_sda;
  assign o_scl_rise = w_ok &  w_scl & ~r_scl_d;
  assign o_scl_fall = w_ok & ~w_scl &  r_scl_d;
endmodule

// File: rtl/i2c_reg_target.sv
// I2C target with an auto-incrementing pointer into a byte register bank.
// Latency: SDA drive changes one clock after the synchronized SCL fall.
// Backpressure: none; SCL is never stretched and local writes always land.
module i2c_reg_target
  import i2c_reg_target_pkg::*;
#(
  parameter int REG_COUNT   = 8,
  parameter int PTR_W       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [6:0]            i_addr,
  input  logic                  i_scl,
  inout  wire                   io_sda,
  i2c_reg_target_if.slave       bus
);
  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_rw;
  logic             r_nack;
  logic             r_sda_oe;
  logic             r_busy;
  logic             r_addressed;
  logic [PTR_W-1:0] r_ptr;
  logic [7:0]       r_regs [REG_COUNT];

  logic             w_sda;
  logic             w_start;
  logic             w_stop;
  logic             w_scl_rise;
  logic             w_scl_fall;
  logic             w_byte_done;
  logic             w_commit;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_scl      (i_scl),
    .i_sda      (io_sda),
    .o_sda      (w_sda),
    .o_start    (w_start),
    .o_stop     (w_stop),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall)
  );

  // Open-drain: only ever pull low.
  assign io_sda = r_sda_oe ? 1'b0 : 1'bz;

  // The ACK slot begins on the SCL fall that follows the 8th sampled bit.
  assign w_byte_done = w_scl_fall && (r_bit_cnt == BYTE_BITS);
  assign w_commit    = (r_state == ST_WRITE) && w_byte_done;

  assign bus.busy      = r_busy;
  assign bus.addressed = r_addressed;
  assign bus.wr_strobe = w_commit;
  assign bus.wr_idx    = r_ptr;
  assign bus.loc_rdata = r_regs[bus.loc_idx];

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: STOP, then START, override every per-state transition.
  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = ST_IDLE;
    end else if (w_start) begin
      w_state_nxt = ST_ADDR;
    end else begin
      case (r_state)
        ST_ADDR:      if (w_byte_done) w_state_nxt = addr_match(r_shift, i_addr) ? ST_ADDR_ACK : ST_WAIT_STOP;
        ST_ADDR_ACK:  if (w_scl_fall)  w_state_nxt = r_rw ? ST_READ : ST_PTR;
        ST_PTR:       if (w_byte_done) w_state_nxt = ST_PTR_ACK;
        ST_PTR_ACK:   if (w_scl_fall)  w_state_nxt = ST_WRITE;
        ST_WRITE:     if (w_byte_done) w_state_nxt = ST_WRITE_ACK;
        ST_WRITE_ACK: if (w_scl_fall)  w_state_nxt = ST_WRITE;
        ST_READ:      if (w_byte_done) w_state_nxt = ST_READ_ACK;
        ST_READ_ACK:  if (w_scl_fall)  w_state_nxt = r_nack ? ST_WAIT_STOP : ST_READ;
        default:      w_state_nxt = r_state;
      endcase
    end
  end

  // Bit shifting, pointer, SDA drive and bus status, all keyed off SCL edges.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rw        <= 1'b0;
      r_nack      <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_addressed <= 1'b0;
      r_ptr       <= '0;
    end else if (w_stop) begin
      r_busy      <= 1'b0;
      r_addressed <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_bit_cnt   <= '0;
    end else if (w_start) begin
      r_busy      <= 1'b1;
      r_addressed <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_bit_cnt   <= '0;
    end else begin
      case (r_state)
        ST_ADDR, ST_PTR, ST_WRITE: begin
          if (w_scl_rise) begin
            r_shift   <= {r_shift[6:0], w_sda};
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end else if (w_byte_done) begin
            r_bit_cnt <= '0;
            if (r_state == ST_ADDR) begin
              r_rw <= r_shift[0];
              if (addr_match(r_shift, i_addr)) begin
                r_sda_oe    <= 1'b1;
                r_addressed <= 1'b1;
              end
            end else if (r_state == ST_PTR) begin
              r_ptr    <= r_shift[PTR_W-1:0];
              r_sda_oe <= 1'b1;
            end else begin
              r_ptr    <= r_ptr + PTR_W'(1);
              r_sda_oe <= 1'b1;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            r_bit_cnt <= '0;
            if (r_rw) begin
              r_shift  <= r_regs[r_ptr];
              r_sda_oe <= ~r_regs[r_ptr][7];
            end else begin
              r_sda_oe <= 1'b0;
            end
          end
        end
        ST_PTR_ACK, ST_WRITE_ACK: begin
          if (w_scl_fall) r_sda_oe <= 1'b0;
        end
        ST_READ: begin
          if (w_scl_rise) begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end else if (w_byte_done) begin
            r_bit_cnt <= '0;
            r_sda_oe  <= 1'b0;
            r_ptr     <= r_ptr + PTR_W'(1);
          end else if (w_scl_fall) begin
            r_shift  <= {r_shift[6:0], 1'b0};
            r_sda_oe <= ~r_shift[6];
          end
        end
        ST_READ_ACK: begin
          if (w_scl_rise) begin
            r_nack <= w_sda;
          end else if (w_scl_fall) begin
            r_bit_cnt <= '0;
            if (!r_nack) begin
              r_shift  <= r_regs[r_ptr];
              r_sda_oe <= ~r_regs[r_ptr][7];
            end else begin
              r_sda_oe <= 1'b0;
            end
          end
        end
        default: r_sda_oe <= 1'b0;
      endcase
    end
  end

  // Register bank: I2C commit first, local write last so it wins a collision.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else begin
      if (w_commit)   r_regs[r_ptr]       <= r_shift;
      if (bus.loc_we) r_regs[bus.loc_idx] <= bus.loc_wdata;
    end
  end
endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bit-banged I2C master plus a register/pointer model.
// Directed scenarios first, then a randomized mix of reads, writes and local writes.
module tb_i2c_reg_target;
  localparam int         Q     = 8;       // clocks per quarter SCL period
  localparam logic [6:0] TADDR = 7'h42;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       scl       = 1'b1;
  logic       m_sda_low = 1'b0;
  logic [6:0] addr      = TADDR;
  logic       collide   = 1'b0;
  logic       tb_we     = 1'b0;
  wire        sda;

  i2c_reg_target_if #(.PTR_W(3)) bus ();

  pullup (sda);
  assign sda        = m_sda_low ? 1'b0 : 1'bz;
  assign bus.loc_we = collide ? bus.wr_strobe : tb_we;

  i2c_reg_target #(.REG_COUNT(8), .PTR_W(3), .SYNC_STAGES(2)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_addr (addr),
    .i_scl  (scl),
    .io_sda (sda),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int         n_pass  = 0;
  int         n_total = 0;
  int         n_fail  = 0;
  logic [7:0] mregs [8];
  int         mptr;
  int         exp_idx [$];
  int         got_idx [$];
  logic [7:0] txq [$];

  always @(negedge clk) if (bus.wr_strobe) got_idx.push_back(int'(bus.wr_idx));

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no end, required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; wq();
    scl = 1'b1;       wq();
    m_sda_low = 1'b1; wq();
    scl = 1'b0;       wq();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wq();
    scl = 1'b1;       wq();
    m_sda_low = 1'b0; wq();
    wq();
  endtask

  task automatic put_bit(input logic b);
    m_sda_low = ~b; wq();
    scl = 1'b1;     wq(); wq();
    scl = 1'b0;     wq();
  endtask

  task automatic get_bit(output logic b);
    m_sda_low = 1'b0; wq();
    scl = 1'b1;       wq();
    b = sda;          wq();
    scl = 1'b0;       wq();
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    ack = ~b;
  endtask

  task automatic get_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(~ack);
  endtask

  task automatic local_write(input int idx, input logic [7:0] d);
    bus.loc_idx   = 3'(idx);
    bus.loc_wdata = d;
    tb_we         = 1'b1;
    @(posedge clk); #1;
    tb_we         = 1'b0;
    mregs[idx]    = d;
  endtask

  task automatic check_regs();
    for (int i = 0; i < 8; i++) begin
      bus.loc_idx = 3'(i);
      #1;
      check($sformatf("reg%0d", i), bus.loc_rdata, mregs[i]);
    end
  endtask

  // Write transaction: pointer byte p, then every byte queued in txq.
  task automatic do_write(input int p);
    logic ack;
    exp_idx.delete();
    got_idx.delete();
    i2c_start();
    check("busy_mid", bus.busy, 1);
    put_byte({TADDR, 1'b0}, ack);
    check("addr_ack", ack, 1);
    check("addressed", bus.addressed, 1);
    put_byte(8'(p), ack);
    check("ptr_ack", ack, 1);
    mptr = p % 8;
    foreach (txq[i]) begin
      put_byte(txq[i], ack);
      check("data_ack", ack, 1);
      mregs[mptr] = txq[i];
      exp_idx.push_back(mptr);
      mptr = (mptr + 1) % 8;
    end
    i2c_stop();
    check("busy_after_stop", bus.busy, 0);
    check("addressed_after_stop", bus.addressed, 0);
    check("strobe_count", got_idx.size(), exp_idx.size());
    foreach (exp_idx[i]) if (i < got_idx.size()) check("wr_idx", got_idx[i], exp_idx[i]);
  endtask

  // Read n bytes, optionally after setting the pointer with a repeated START.
  task automatic do_read(input int n, input logic set_ptr, input int p);
    logic       ack;
    logic [7:0] d;
    i2c_start();
    if (set_ptr) begin
      put_byte({TADDR, 1'b0}, ack);
      check("rs_addr_ack", ack, 1);
      put_byte(8'(p), ack);
      check("rs_ptr_ack", ack, 1);
      mptr = p % 8;
      i2c_start();
    end
    put_byte({TADDR, 1'b1}, ack);
    check("raddr_ack", ack, 1);
    for (int i = 0; i < n; i++) begin
      get_byte(d, i != n - 1);
      check("rd_data", d, mregs[mptr]);
      mptr = (mptr + 1) % 8;
    end
    check("sda_released_after_nack", sda, 1);
    i2c_stop();
  endtask

  initial begin
    logic ack;
    logic b;
    int   op;
    int   p;
    int   n;

    bus.loc_idx   = '0;
    bus.loc_wdata = '0;
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
    mptr = 0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", bus.busy, 0);
    check("rst_addressed", bus.addressed, 0);
    check("rst_wr_strobe", bus.wr_strobe, 0);
    check("rst_sda", sda, 1);
    check_regs();
    wq();

    // Basic write with auto-increment.
    txq = {8'hAA, 8'h55};
    do_write(3);
    check_regs();

    // Pointer wrap.
    txq = {8'h11, 8'h22};
    do_write(7);
    check_regs();

    // Preloaded bytes read back through a repeated START.
    local_write(2, 8'h10);
    local_write(3, 8'h20);
    local_write(4, 8'h30);
    do_read(3, 1'b1, 2);

    // Wrong address: no ACK, no strobes, stays off the bus until STOP.
    got_idx.delete();
    i2c_start();
    put_byte({7'h43, 1'b0}, ack);
    check("wrong_addr_nack", ack, 0);
    check("wrong_addr_addressed", bus.addressed, 0);
    put_byte(8'h00, ack);
    check("wait_stop_nack", ack, 0);
    check("wait_stop_busy", bus.busy, 1);
    i2c_stop();
    check("wrong_addr_strobes", got_idx.size(), 0);
    check("wrong_addr_busy", bus.busy, 0);

    // Local write collides with the I2C commit to the same index.
    bus.loc_idx   = 3'd5;
    bus.loc_wdata = 8'hEE;
    collide       = 1'b1;
    txq = {8'h77};
    do_write(5);
    collide  = 1'b0;
    mregs[5] = 8'hEE;
    check_regs();

    // Reset in the 4th bit of a read byte while the target drives SDA low.
    local_write(3, 8'h00);
    i2c_start();
    put_byte({TADDR, 1'b0}, ack);
    put_byte(8'h03, ack);
    i2c_start();
    put_byte({TADDR, 1'b1}, ack);
    check("rst_seq_raddr_ack", ack, 1);
    for (int i = 0; i < 3; i++) get_bit(b);
    m_sda_low = 1'b0; wq();
    scl = 1'b1;       wq();
    check("sda_driven_before_rst", sda, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("sda_released_after_rst", sda, 1);
    check("busy_after_rst", bus.busy, 0);
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
    mptr = 0;
    scl = 1'b0; wq();
    i2c_stop();
    check_regs();
    local_write(0, 8'h5A);
    do_read(1, 1'b0, 0);
    txq = {8'hC3, 8'h3C};
    do_write(6);
    check_regs();

    // Randomized mix checked against the model.
    for (int it = 0; it < 8; it++) begin
      op = int'($urandom_range(0, 2));
      p  = int'($urandom_range(0, 255));
      n  = int'($urandom_range(1, 3));
      if (op == 0) begin
        txq.delete();
        for (int k = 0; k < n; k++) txq.push_back(8'($urandom));
        do_write(p);
      end else if (op == 1) begin
        do_read(n, 1'($urandom_range(0, 1)), p);
      end else begin
        local_write(p % 8, 8'($urandom));
      end
    end
    check_regs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
